// File: rtl/rgb_weighted_unmerger.sv
// rgb_weighted_unmerger: recovers the layer-2 pixel from a weighted blend and its known layer-1 pixel
// using three 17-step restoring dividers that share one FSM and one iteration counter.
module rgb_weighted_unmerger (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rm_in,
    input  logic [7:0] gm_in,
    input  logic [7:0] bm_in,
    input  logic [7:0] r1_in,
    input  logic [7:0] g1_in,
    input  logic [7:0] b1_in,
    input  logic [7:0] weight1,
    input  logic [7:0] weight2,
    input  logic       data_valid,
    output logic       in_ready,
    output logic [7:0] r2_out,
    output logic [7:0] g2_out,
    output logic [7:0] b2_out,
    output logic       data_out_valid
);
    typedef enum logic [1:0] {IDLE, SETUP, DIV} state_t;
    state_t state, state_nxt;
    logic [7:0] w1_r, w2_r;
    logic [4:0] cnt;
    logic [2:0][7:0] m_in, c1_in;
    logic accept, last_step;
    assign m_in  = {bm_in, gm_in, rm_in};
    assign c1_in = {b1_in, g1_in, r1_in};
    assign in_ready  = state == IDLE;
    assign accept    = in_ready && data_valid;
    assign last_step = state == DIV && cnt == 5'd17;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = data_valid ? SETUP : IDLE;
            SETUP:   state_nxt = DIV;
            DIV:     state_nxt = cnt == 5'd17 ? IDLE : DIV;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            w1_r           <= '0;
            w2_r           <= '0;
            cnt            <= '0;
            data_out_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            data_out_valid <= last_step;
            if (accept) begin
                w1_r <= weight1;
                w2_r <= weight2;
            end
            cnt <= state == SETUP ? 5'd0 : state == DIV ? cnt + 5'd1 : cnt;
        end
    end
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [7:0]  m_r, c1_r, out_r, res;
        logic [16:0] prod_m, num, quo;
        logic [15:0] prod_c;
        logic [17:0] diff;
        logic [8:0]  rem, rsh;
        logic        ge;
        assign prod_m = {9'd0, m_r} * ({8'd0, w1_r} + {8'd0, w2_r});
        assign prod_c = {8'd0, c1_r} * {8'd0, w1_r};
        assign diff   = {1'b0, prod_m} - {2'b0, prod_c};
        // A negative numerator means layer 1 over-explains the blend; treat layer 2 as black.
        assign num    = diff[17] ? 17'd0 : diff[16:0];
        assign rsh    = {rem[7:0], quo[16]};
        assign ge     = rsh >= {1'b0, w2_r};
        assign res    = w2_r == 8'd0 ? 8'd0 : |quo[16:8] ? 8'hff : quo[7:0];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                m_r   <= '0;
                c1_r  <= '0;
                quo   <= '0;
                rem   <= '0;
                out_r <= '0;
            end else begin
                if (accept) begin
                    m_r  <= m_in[c];
                    c1_r <= c1_in[c];
                end
                if (state == SETUP) begin
                    quo <= num;
                    rem <= '0;
                end
                if (state == DIV && !last_step) begin
                    rem <= ge ? rsh - {1'b0, w2_r} : rsh;
                    quo <= {quo[15:0], ge};
                end
                if (last_step) out_r <= res;
            end
        end
    end
    assign r2_out = g_ch[0].out_r;
    assign g2_out = g_ch[1].out_r;
    assign b2_out = g_ch[2].out_r;
endmodule

// File: tb/tb_rgb_weighted_unmerger.sv
// tb_rgb_weighted_unmerger: randomized and directed checks of the unmerger against an
// arithmetic reference model, plus handshake, throughput and mid-operation reset behaviour.
module tb_rgb_weighted_unmerger;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] rm_in, gm_in, bm_in, r1_in, g1_in, b1_in, weight1, weight2;
    logic data_valid, in_ready, data_out_valid;
    logic [7:0] r2_out, g2_out, b2_out;
    int checks = 0;
    int failures = 0;

    rgb_weighted_unmerger dut (
        .clk(clk), .rst(rst),
        .rm_in(rm_in), .gm_in(gm_in), .bm_in(bm_in),
        .r1_in(r1_in), .g1_in(g1_in), .b1_in(b1_in),
        .weight1(weight1), .weight2(weight2),
        .data_valid(data_valid), .in_ready(in_ready),
        .r2_out(r2_out), .g2_out(g2_out), .b2_out(b2_out),
        .data_out_valid(data_out_valid)
    );

    always #5 clk = ~clk;

    function automatic int ref_ch(int m, int c1, int w1, int w2);
        int num;
        if (w2 == 0) return 0;
        num = m * (w1 + w2) - c1 * w1;
        if (num < 0) num = 0;
        num = num / w2;
        return num > 255 ? 255 : num;
    endfunction

    function automatic logic [23:0] ref_px(logic [23:0] m, logic [23:0] c1, logic [7:0] w1, logic [7:0] w2);
        logic [7:0] r, g, b;
        r = 8'(ref_ch(int'(m[23:16]), int'(c1[23:16]), int'(w1), int'(w2)));
        g = 8'(ref_ch(int'(m[15:8]), int'(c1[15:8]), int'(w1), int'(w2)));
        b = 8'(ref_ch(int'(m[7:0]), int'(c1[7:0]), int'(w1), int'(w2)));
        return {r, g, b};
    endfunction

    task automatic drive(input logic [23:0] m, input logic [23:0] c1, input logic [7:0] w1, input logic [7:0] w2);
        {rm_in, gm_in, bm_in} = m;
        {r1_in, g1_in, b1_in} = c1;
        weight1 = w1;
        weight2 = w2;
    endtask

    task automatic wait_ready;
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_wait got=0 want=1");
        end
    endtask

    task automatic run_pixel(input logic [23:0] m, input logic [23:0] c1, input logic [7:0] w1,
                             input logic [7:0] w2, output logic [23:0] got, output int lat);
        wait_ready();
        drive(m, c1, w1, w2);
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        lat = 0;
        got = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (data_out_valid) begin
                lat = i;
                got = {r2_out, g2_out, b2_out};
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        data_valid = 1'b0;
        drive(24'h0, 24'h0, 8'h0, 8'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, data_out_valid, r2_out, g2_out, b2_out} !== {1'b1, 1'b0, 24'h0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%b v=%b out=%h want rdy=1 v=0 out=000000",
                     in_ready, data_out_valid, {r2_out, g2_out, b2_out});
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [7:0] tm [5] = '{8'd100, 8'd77, 8'd10, 8'd255, 8'd10};
        logic [7:0] tc [5] = '{8'd50, 8'd33, 8'd200, 8'd0, 8'd0};
        logic [7:0] tw1 [5] = '{8'd128, 8'd5, 8'd200, 8'd255, 8'd1};
        logic [7:0] tw2 [5] = '{8'd128, 8'd0, 8'd10, 8'd1, 8'd3};
        logic [7:0] te [5] = '{8'd150, 8'd0, 8'd0, 8'd255, 8'd13};
        logic [23:0] got;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_pixel({3{tm[i]}}, {3{tc[i]}}, tw1[i], tw2[i], got, lat);
            checks++;
            if (got !== {3{te[i]}}) begin
                failures++;
                $display("FAIL directed_%0d got=%h want=%h", i, got, {3{te[i]}});
            end
            checks++;
            if (lat !== 19) begin
                failures++;
                $display("FAIL directed_latency_%0d got=%0d want=19", i, lat);
            end
        end
    endtask

    task automatic test_random;
        logic [23:0] m, c1, got, exp;
        logic [7:0] w1, w2;
        int lat;
        for (int i = 0; i < 24; i++) begin
            m  = 24'($urandom);
            c1 = (i % 3 == 0) ? 24'($urandom) : 24'($urandom) & 24'h3f3f3f;
            w1 = 8'($urandom);
            w2 = (i % 6 == 5) ? 8'd0 : 8'($urandom_range(1, 255));
            exp = ref_px(m, c1, w1, w2);
            run_pixel(m, c1, w1, w2, got, lat);
            checks++;
            if (got !== exp || lat !== 19) begin
                failures++;
                $display("FAIL random_%0d got=%h lat=%0d want=%h lat=19 (m=%h c1=%h w1=%0d w2=%0d)",
                         i, got, lat, exp, m, c1, w1, w2);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] q_exp [$];
        int acc_cyc [$];
        int outs = 0;
        logic [23:0] m, c1, exp;
        logic [7:0] w1, w2;
        bit acc, prev_v;
        prev_v = 1'b0;
        wait_ready();
        m = 24'($urandom); c1 = 24'($urandom) & 24'h1f1f1f; w1 = 8'($urandom); w2 = 8'($urandom_range(1, 255));
        drive(m, c1, w1, w2);
        data_valid = 1'b1;
        for (int cyc = 0; cyc < 150 && outs < 4; cyc++) begin
            acc = in_ready && data_valid;
            @(posedge clk);
            #1;
            if (acc) begin
                q_exp.push_back(ref_px(m, c1, w1, w2));
                acc_cyc.push_back(cyc);
                m = 24'($urandom); c1 = 24'($urandom) & 24'h1f1f1f; w1 = 8'($urandom); w2 = 8'($urandom_range(1, 255));
                drive(m, c1, w1, w2);
            end
            if (data_out_valid) begin
                outs++;
                exp = q_exp.size() > 0 ? q_exp.pop_front() : 24'hxxxxxx;
                checks++;
                if ({r2_out, g2_out, b2_out} !== exp || prev_v) begin
                    failures++;
                    $display("FAIL b2b_out_%0d got=%h prev_v=%b want=%h prev_v=0", outs, {r2_out, g2_out, b2_out}, prev_v, exp);
                end
            end
            prev_v = data_out_valid;
            @(negedge clk);
        end
        data_valid = 1'b0;
        checks++;
        if (outs !== 4 || acc_cyc.size() < 4) begin
            failures++;
            $display("FAIL b2b_count got outs=%0d accepts=%0d want outs=4 accepts>=4", outs, acc_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 20) begin
                    failures++;
                    $display("FAIL b2b_spacing_%0d got=%0d want=20", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_ignore_busy;
        logic [23:0] ma, ca, got, exp;
        logic [7:0] wa1, wa2;
        int nv = 0;
        int lat = 0;
        ma = 24'h60a0c8; ca = 24'h102030; wa1 = 8'd40; wa2 = 8'd90;
        exp = ref_px(ma, ca, wa1, wa2);
        got = 'x;
        wait_ready();
        drive(ma, ca, wa1, wa2);
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                drive(~ma, ~ca, 8'd7, 8'd3);
                data_valid = 1'b1;
            end
            if (i == 12) data_valid = 1'b0;
            if (data_out_valid) begin
                nv++;
                lat = i;
                got = {r2_out, g2_out, b2_out};
            end
        end
        checks++;
        if (nv !== 1 || got !== exp || lat !== 19) begin
            failures++;
            $display("FAIL ignore_busy got n=%0d out=%h lat=%0d want n=1 out=%h lat=19", nv, got, lat, exp);
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] got, exp, m, c1;
        int nv = 0;
        int lat;
        wait_ready();
        drive(24'h646464, 24'h323232, 8'd128, 8'd128);
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, data_out_valid, r2_out, g2_out, b2_out} !== {1'b1, 1'b0, 24'h0}) begin
            failures++;
            $display("FAIL reset_mid_state got rdy=%b v=%b out=%h want rdy=1 v=0 out=000000",
                     in_ready, data_out_valid, {r2_out, g2_out, b2_out});
        end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (data_out_valid) nv++;
        end
        checks++;
        if (nv !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_valid got=%0d want=0", nv);
        end
        m = 24'hff0a64; c1 = 24'h00c832;
        exp = ref_px(m, c1, 8'd25, 8'd60);
        run_pixel(m, c1, 8'd25, 8'd60, got, lat);
        checks++;
        if (got !== exp || lat !== 19) begin
            failures++;
            $display("FAIL reset_mid_recover got=%h lat=%0d want=%h lat=19", got, lat, exp);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
